// File: rtl/encoder_148.sv
// Registered 8-to-3 active-low priority encoder with the 74HC148 pinout.
// Inputs are decoded combinationally and every output is a flop, so latency is one cycle.
module encoder_148 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] DataIn,
  output logic       EO,
  output logic [2:0] Dataout,
  input  logic       EI,
  output logic       GS
);

  logic [2:0] dataout_d, dataout_q;
  logic       gs_d, gs_q;
  logic       eo_d, eo_q;
  logic [2:0] code;

  // Ascending scan so the highest active (low) request index wins.
  always_comb begin
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!DataIn[i]) begin
        code = 3'(i);
      end
    end
  end

  always_comb begin
    dataout_d = 3'b111;
    gs_d      = 1'b1;
    eo_d      = 1'b1;
    if (!EI) begin
      if (&DataIn) begin
        eo_d = 1'b0;
      end else begin
        gs_d      = 1'b0;
        dataout_d = ~code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataout_q <= 3'b111;
      gs_q      <= 1'b1;
      eo_q      <= 1'b1;
    end else begin
      dataout_q <= dataout_d;
      gs_q      <= gs_d;
      eo_q      <= eo_d;
    end
  end

  assign Dataout = dataout_q;
  assign GS      = gs_q;
  assign EO      = eo_q;

endmodule

// File: tb/tb_encoder_148.sv
// Directed bench for encoder_148: reset, disable, idle, walking request, priority and
// mid-sequence reset, with outputs sampled 1 time unit after each rising edge.
module tb_encoder_148;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] DataIn;
  logic       EO;
  logic [2:0] Dataout;
  logic       EI;
  logic       GS;

  int n_checks = 0;
  int n_fail   = 0;

  encoder_148 dut (
    .clk    (clk),
    .rst    (rst),
    .DataIn (DataIn),
    .EO     (EO),
    .Dataout(Dataout),
    .EI     (EI),
    .GS     (GS)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic e, input logic [7:0] d);
    rst    = r;
    EI     = e;
    DataIn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] ed, input logic eg, input logic ee);
    n_checks++;
    assert ({Dataout, GS, EO} === {ed, eg, ee}) else begin
      n_fail++;
      $error("FAIL %s: Dataout/GS/EO got %b/%b/%b expected %b/%b/%b",
             tag, Dataout, GS, EO, ed, eg, ee);
    end
    n_checks++;
    assert (!(GS === 1'b0 && EO === 1'b0)) else begin
      n_fail++;
      $error("FAIL %s_gs_eo: GS/EO got %b/%b expected not both 0", tag, GS, EO);
    end
  endtask

  logic [7:0] walk_din [8];
  logic [2:0] walk_exp [8];

  initial begin
    walk_din = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    walk_exp = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};

    // Reset held for two edges with an active request that must be ignored.
    apply(1'b1, 1'b0, 8'h00);
    check("reset_1", 3'b111, 1'b1, 1'b1);
    apply(1'b1, 1'b0, 8'h00);
    check("reset_2", 3'b111, 1'b1, 1'b1);

    apply(1'b0, 1'b1, 8'h00);
    check("disabled", 3'b111, 1'b1, 1'b1);

    apply(1'b0, 1'b0, 8'hFF);
    check("idle", 3'b111, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, walk_din[i]);
      check($sformatf("walk_%0d", i), walk_exp[i], 1'b0, 1'b1);
    end

    apply(1'b0, 1'b0, 8'b0101_0101);
    check("prio_55", 3'b000, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 8'b1111_0000);
    check("prio_f0", 3'b100, 1'b0, 1'b1);

    // Input change between edges must not reach the outputs.
    DataIn = 8'hFF;
    EI     = 1'b1;
    #2;
    check("no_comb_path", 3'b100, 1'b0, 1'b1);

    apply(1'b0, 1'b1, 8'h00);
    check("disable_after_req", 3'b111, 1'b1, 1'b1);

    // Inputs change every cycle, reset lands mid-sequence.
    apply(1'b0, 1'b0, 8'h7F);
    check("seq_7f", 3'b000, 1'b0, 1'b1);
    apply(1'b1, 1'b0, 8'hBF);
    check("seq_rst", 3'b111, 1'b1, 1'b1);
    apply(1'b0, 1'b0, 8'hEF);
    check("seq_ef", 3'b011, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 8'hFF);
    check("seq_ff", 3'b111, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 8'hFB);
    check("seq_fb", 3'b101, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_148.md
ENCODER_148 -- requirements
Module: encoder_148

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset; sampled on rising clk edge.
REQ-005 DataIn  input  8  active-low request lines; DataIn[7] highest priority, DataIn[0] lowest.
REQ-006 EO  output  1  active-low enable output for cascading; low only when enabled and no request is active.
REQ-007 Dataout  output  3  active-low (inverted) binary code of the highest-priority active request.
REQ-008 EI  input  1  active-low enable input; high disables the encoder.
REQ-009 GS  output  1  active-low group-select; low when enabled and at least one request is active.
REQ-010 Positional port order after clk, rst: DataIn, EO, Dataout, EI, GS.

Function
REQ-011 Functionally a registered 74HC148: the next-state value is decoded combinationally from EI and DataIn, then captured on each rising clk edge.
REQ-012 Latency: exactly 1 clock cycle from sampled inputs to outputs; no combinational input-to-output path.
REQ-013 Disabled (EI=1), DataIn ignored: next Dataout=3'b111, GS=1, EO=1.
REQ-014 Enabled with no request (EI=0, DataIn=8'hFF): next Dataout=3'b111, GS=1, EO=0.
REQ-015 Enabled with a request (EI=0, any DataIn bit 0):
 - n = highest index with DataIn[n]=0.
 - next Dataout=~n (3-bit inverted).
 - GS=0, EO=1.
REQ-016 Code mapping (active-low):
 - n=7 -> 000, 6 -> 001, 5 -> 010, 4 -> 011.
 - n=3 -> 100, 2 -> 101, 1 -> 110, 0 -> 111.
REQ-017 Priority: lower-index bits are don't-care once a higher bit is 0 (e.g. 8'b00000000 -> 000).
REQ-018 GS and EO are never both 0 in any cycle.
REQ-019 Dataout=111 with GS=0 indicates request 0 only; Dataout=111 with GS=1 indicates no valid code.
REQ-020 X/Z on inputs is not required to be handled; outputs are defined for all 0/1 input combinations.

Reset
REQ-021 When rst=1 at a rising edge, outputs load the disabled state: Dataout=3'b111, GS=1, EO=1, regardless of EI and DataIn.
REQ-022 Reset has priority over normal operation.
REQ-023 Normal decoding resumes on the first rising edge with rst=0.
REQ-024 Reset asserted mid-operation overrides any pending encoded value on that same edge.
REQ-025 Before the first reset edge, outputs are undefined.

Verification
REQ-026 rst=1 for 2 cycles with EI=0, DataIn=8'h00 -> Dataout=111, GS=1, EO=1 while reset is applied.
REQ-027 EI=1, DataIn=8'h00 -> one cycle later Dataout=111, GS=1, EO=1.
REQ-028 EI=0, DataIn=8'hFF -> Dataout=111, GS=1, EO=0.
REQ-029 EI=0, DataIn walking a single zero from bit 0 to bit 7 (FE, FD, FB, F7, EF, DF, BF, 7F), one value per cycle:
 - Dataout = 111, 110, 101, 100, 011, 010, 001, 000, each one cycle after its input.
 - GS=0 and EO=1 throughout.
REQ-030 EI=0, DataIn=8'b01010101 -> Dataout=000, GS=0; then DataIn=8'b11110000 -> Dataout=100, GS=0, EO=1.
REQ-031 Change inputs every cycle, then assert rst mid-sequence -> outputs equal the disabled state on the reset edge and track inputs again with 1-cycle latency after release.
